// File: rtl/forward_mac_layer_if.sv
// rtl/forward_mac_layer_if.sv - handshake bundle for the forward MAC layer
interface forward_mac_layer_if #(
  parameter int NP = 4,
  parameter int NC = 4,
  parameter int WF = 4
);
  logic                        iValid_AS_WeightBias;
  logic                        oReady_AS_WeightBias;
  logic [NC*NP*WF+NC*WF-1:0]   iData_AS_WeightBias;
  logic                        iValid_AS_State0;
  logic                        oReady_AS_State0;
  logic [NP*WF-1:0]            iData_AS_State0;
  logic                        oValid_BM_State1;
  logic                        iReady_BM_State1;
  logic [NC*WF-1:0]            oData_BM_State1;

  // Environment side: feeds weight/bias and parent state, consumes child state
  modport master (
    output iValid_AS_WeightBias, iData_AS_WeightBias,
    input  oReady_AS_WeightBias,
    output iValid_AS_State0, iData_AS_State0,
    input  oReady_AS_State0,
    input  oValid_BM_State1, oData_BM_State1,
    output iReady_BM_State1
  );

  // Layer side
  modport slave (
    input  iValid_AS_WeightBias, iData_AS_WeightBias,
    output oReady_AS_WeightBias,
    input  iValid_AS_State0, iData_AS_State0,
    output oReady_AS_State0,
    output oValid_BM_State1, oData_BM_State1,
    input  iReady_BM_State1
  );
endinterface

// File: rtl/forward_mac_layer.sv
// rtl/forward_mac_layer.sv - serial-MAC neuron layer, optional ReLU via FORWARD_MAC_RELU_EN
module forward_mac_layer #(
  parameter int NP = 4,
  parameter int NC = 4,
  parameter int WF = 4
) (
  input logic              iCLK,
  input logic              iRST_N,
  forward_mac_layer_if.slave bus
);

  localparam int WBW  = NC*NP*WF + NC*WF;
  localparam int AW   = WF + $clog2(NP) + 2;
  localparam int KW   = (NP > 1) ? $clog2(NP) : 1;
  localparam int MAXV = (2**(WF-1)) - 1;
  localparam int MINV = -(2**(WF-1));

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

  state_t                 state_q;
  logic                   f_wb_q;
  logic                   f_st_q;
  logic [WBW-1:0]         wb_q;
  logic [NP*WF-1:0]       st_q;
  logic [KW-1:0]          k_q;
  logic signed [AW-1:0]   acc_q [NC];
  logic                   valid_q;
  logic [NC*WF-1:0]       data_q;

  logic                   wb_rdy;
  logic                   st_rdy;
  logic signed [WF-1:0]   x_k;
  logic signed [WF-1:0]   w_jk  [NC];
  logic signed [2*WF-1:0] prod  [NC];
  logic [WF-1:0]          p_jk  [NC];
  logic signed [AW-1:0]   acc_d [NC];
  logic [NC*WF-1:0]       y_d;

  // Readies depend only on registered state, never on the downstream ready
  assign wb_rdy = (state_q == S_IDLE) && !f_wb_q;
  assign st_rdy = (state_q == S_IDLE) && !f_st_q;

  assign bus.oReady_AS_WeightBias = wb_rdy;
  assign bus.oReady_AS_State0     = st_rdy;
  assign bus.oValid_BM_State1     = valid_q;
  assign bus.oData_BM_State1      = data_q;

  // One MAC step for every lane at parent index k, plus the saturated/activated view of it
  always_comb begin
    x_k = st_q[k_q*WF +: WF];
    y_d = '0;
    for (int j = 0; j < NC; j++) begin
      w_jk[j]  = wb_q[NC*WF + j*NP*WF + k_q*WF +: WF];
      prod[j]  = x_k * w_jk[j];
      p_jk[j]  = prod[j][WF-1 +: WF];
      acc_d[j] = acc_q[j] + {{(AW-WF){p_jk[j][WF-1]}}, p_jk[j]};
      if (acc_d[j] > AW'(MAXV)) begin
        y_d[j*WF +: WF] = WF'(MAXV);
      end else if (acc_d[j] < AW'(MINV)) begin
        y_d[j*WF +: WF] = WF'(MINV);
      end else begin
        y_d[j*WF +: WF] = acc_d[j][WF-1:0];
      end
`ifdef FORWARD_MAC_RELU_EN
      if (y_d[j*WF + WF - 1]) begin
        y_d[j*WF +: WF] = '0;
      end
`else
`endif
    end
  end

  // Input capture, IDLE/ACC/OUT sequencing and registered output stage
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
      f_wb_q  <= 1'b0;
      f_st_q  <= 1'b0;
      wb_q    <= '0;
      st_q    <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      for (int j = 0; j < NC; j++) begin
        acc_q[j] <= '0;
      end
    end else begin
      if (bus.iValid_AS_WeightBias && wb_rdy) begin
        wb_q   <= bus.iData_AS_WeightBias;
        f_wb_q <= 1'b1;
      end
      if (bus.iValid_AS_State0 && st_rdy) begin
        st_q   <= bus.iData_AS_State0;
        f_st_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (f_wb_q && f_st_q) begin
            state_q <= S_ACC;
            k_q     <= '0;
            for (int j = 0; j < NC; j++) begin
              acc_q[j] <= {{(AW-WF){wb_q[j*WF + WF - 1]}}, wb_q[j*WF +: WF]};
            end
          end
        end
        S_ACC: begin
          for (int j = 0; j < NC; j++) begin
            acc_q[j] <= acc_d[j];
          end
          k_q <= k_q + 1'b1;
          if (k_q == KW'(NP-1)) begin
            state_q <= S_OUT;
            valid_q <= 1'b1;
            data_q  <= y_d;
          end
        end
        S_OUT: begin
          if (bus.iReady_BM_State1) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            f_wb_q  <= 1'b0;
            f_st_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
